// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared trap/interrupt codes, bit indices and sequencer state encoding
package csr_pkg;

   // Exception code field width carried from the execute stage
   localparam int EXC_CODE_W = 5;

   // Machine interrupt codes as written into mcause
   localparam logic [EXC_CODE_W-1:0] CODE_MEI = 5'd11;
   localparam logic [EXC_CODE_W-1:0] CODE_MSI = 5'd3;
   localparam logic [EXC_CODE_W-1:0] CODE_MTI = 5'd7;

   // Bit positions of each source in mie and mip
   localparam int MIX_MEI_BIT = 11;
   localparam int MIX_MTI_BIT = 7;
   localparam int MIX_MSI_BIT = 3;

   // Bit positions inside the irq_pending mirror {ext, timer, soft}
   localparam int PEND_EXT   = 2;
   localparam int PEND_TIMER = 1;
   localparam int PEND_SOFT  = 0;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FLUSH    = 3'd1,
      ST_DRAIN    = 3'd2,
      ST_COMMIT   = 3'd3,
      ST_REDIRECT = 3'd4
   } seq_state_e;

   // mcause interrupt flag sits in the top bit of the register
   function automatic int mcause_int_pos(int xlen);
      return xlen - 1;
   endfunction

endpackage

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - multi-flop synchronizer for the asynchronous external interrupt level
module irq_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic level,
   output logic synced
);

   logic [STAGES-1:0] chain;

   // Shift the raw level through the flop chain; cleared on reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], level};
      end
   end

   assign synced = chain[STAGES-1];

endmodule

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - trap/interrupt/MRET sequencer; VECTORED_MTVEC_EN enables vectored interrupt targets
module trap_sequencer
   import csr_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  exc_valid,
   input  logic [EXC_CODE_W-1:0] exc_cause,
   input  logic [XLEN-1:0]       exc_pc,
   input  logic                  mret_valid,
   input  logic [XLEN-1:0]       irq_pc,
   input  logic                  irq_ext,
   input  logic                  irq_timer,
   input  logic                  irq_soft,
   input  logic                  csr_mstatus_mie,
   input  logic [XLEN-1:0]       csr_mie,
   input  logic [XLEN-1:0]       csr_mtvec,
   input  logic [XLEN-1:0]       csr_mepc,
   input  logic                  pipe_drained,
   output logic                  flush,
   output logic                  stall_fetch,
   output logic                  trap_commit,
   output logic [XLEN-1:0]       trap_cause,
   output logic [XLEN-1:0]       trap_epc,
   output logic                  mret_commit,
   output logic                  redirect_valid,
   output logic [XLEN-1:0]       redirect_pc,
   output logic [2:0]            irq_pending,
   output logic                  busy
);

   localparam int INT_BIT = mcause_int_pos(XLEN);

   seq_state_e            state;
   logic                  ext_sync;
   logic                  lat_mret;
   logic                  lat_irq;
   logic [EXC_CODE_W-1:0] lat_code;
   logic                  irq_take;
   logic [EXC_CODE_W-1:0] irq_code;
   logic [XLEN-1:0]       irq_cause;
   logic [XLEN-1:0]       exc_mcause;
   logic [XLEN-1:0]       trap_base;
   logic [XLEN-1:0]       trap_target;
   logic                  unused_bits;

   irq_sync #(.STAGES(SYNC_STAGES)) u_irq_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .level   (irq_ext),
      .synced  (ext_sync)
   );

   // Highest-priority eligible interrupt (MEI > MSI > MTI) from the registered pending mirror
   always_comb begin
      irq_take = 1'b0;
      irq_code = '0;
      if (csr_mstatus_mie) begin
         if (csr_mie[MIX_MEI_BIT] && irq_pending[PEND_EXT]) begin
            irq_take = 1'b1;
            irq_code = CODE_MEI;
         end else if (csr_mie[MIX_MSI_BIT] && irq_pending[PEND_SOFT]) begin
            irq_take = 1'b1;
            irq_code = CODE_MSI;
         end else if (csr_mie[MIX_MTI_BIT] && irq_pending[PEND_TIMER]) begin
            irq_take = 1'b1;
            irq_code = CODE_MTI;
         end
      end
   end

   // mcause encodings for interrupt and exception traps
   always_comb begin
      irq_cause                   = '0;
      irq_cause[EXC_CODE_W-1:0]   = irq_code;
      irq_cause[INT_BIT]          = 1'b1;
      exc_mcause                  = '0;
      exc_mcause[EXC_CODE_W-1:0]  = exc_cause;
   end

   // Trap handler address; vectored mode offsets interrupts by 4*code
   always_comb begin
      trap_base   = {csr_mtvec[XLEN-1:2], 2'b00};
      trap_target = trap_base;
`ifdef VECTORED_MTVEC_EN
      if (lat_irq && (csr_mtvec[1:0] == 2'b01)) begin
         trap_target = trap_base + {{(XLEN-EXC_CODE_W-2){1'b0}}, lat_code, 2'b00};
      end
`endif
   end

   assign unused_bits = ^{csr_mie, csr_mtvec[1:0], csr_mepc[0], lat_irq, lat_code};

   // Sequencer FSM with registered outputs and the pending-interrupt mirror
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= ST_IDLE;
         flush          <= 1'b0;
         stall_fetch    <= 1'b0;
         trap_commit    <= 1'b0;
         mret_commit    <= 1'b0;
         redirect_valid <= 1'b0;
         busy           <= 1'b0;
         trap_cause     <= '0;
         trap_epc       <= '0;
         redirect_pc    <= '0;
         irq_pending    <= '0;
         lat_mret       <= 1'b0;
         lat_irq        <= 1'b0;
         lat_code       <= '0;
      end else begin
         irq_pending <= {ext_sync, irq_timer, irq_soft};
         case (state)
            ST_IDLE: begin
               if (exc_valid || mret_valid || irq_take) begin
                  state       <= ST_FLUSH;
                  flush       <= 1'b1;
                  stall_fetch <= 1'b1;
                  busy        <= 1'b1;
               end
               if (exc_valid) begin
                  lat_mret   <= 1'b0;
                  lat_irq    <= 1'b0;
                  trap_cause <= exc_mcause;
                  trap_epc   <= exc_pc;
               end else if (mret_valid) begin
                  lat_mret <= 1'b1;
                  lat_irq  <= 1'b0;
               end else if (irq_take) begin
                  lat_mret   <= 1'b0;
                  lat_irq    <= 1'b1;
                  lat_code   <= irq_code;
                  trap_cause <= irq_cause;
                  trap_epc   <= irq_pc;
               end
            end
            ST_FLUSH: begin
               flush <= 1'b0;
               state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (pipe_drained) begin
                  state       <= ST_COMMIT;
                  trap_commit <= !lat_mret;
                  mret_commit <= lat_mret;
               end
            end
            ST_COMMIT: begin
               trap_commit    <= 1'b0;
               mret_commit    <= 1'b0;
               redirect_valid <= 1'b1;
               redirect_pc    <= lat_mret ? {csr_mepc[XLEN-1:1], 1'b0} : trap_target;
               state          <= ST_REDIRECT;
            end
            ST_REDIRECT: begin
               redirect_valid <= 1'b0;
               stall_fetch    <= 1'b0;
               busy           <= 1'b0;
               state          <= ST_IDLE;
            end
            default: begin
               state          <= ST_IDLE;
               flush          <= 1'b0;
               stall_fetch    <= 1'b0;
               trap_commit    <= 1'b0;
               mret_commit    <= 1'b0;
               redirect_valid <= 1'b0;
               busy           <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - self-checking bench for trap_sequencer with a transaction-level reference model
module tb_trap_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        exc_valid;
   logic [4:0]  exc_cause;
   logic [31:0] exc_pc;
   logic        mret_valid;
   logic [31:0] irq_pc;
   logic        irq_ext;
   logic        irq_timer;
   logic        irq_soft;
   logic        csr_mstatus_mie;
   logic [31:0] csr_mie;
   logic [31:0] csr_mtvec;
   logic [31:0] csr_mepc;
   logic        pipe_drained;
   logic        flush;
   logic        stall_fetch;
   logic        trap_commit;
   logic [31:0] trap_cause;
   logic [31:0] trap_epc;
   logic        mret_commit;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [2:0]  irq_pending;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [1:0]  kind;   // 0 none, 1 trap, 2 mret
      logic [31:0] cause;
      logic [31:0] epc;
      logic [31:0] target;
   } pred_t;

   trap_sequencer #(.XLEN(32), .SYNC_STAGES(2)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .exc_valid       (exc_valid),
      .exc_cause       (exc_cause),
      .exc_pc          (exc_pc),
      .mret_valid      (mret_valid),
      .irq_pc          (irq_pc),
      .irq_ext         (irq_ext),
      .irq_timer       (irq_timer),
      .irq_soft        (irq_soft),
      .csr_mstatus_mie (csr_mstatus_mie),
      .csr_mie         (csr_mie),
      .csr_mtvec       (csr_mtvec),
      .csr_mepc        (csr_mepc),
      .pipe_drained    (pipe_drained),
      .flush           (flush),
      .stall_fetch     (stall_fetch),
      .trap_commit     (trap_commit),
      .trap_cause      (trap_cause),
      .trap_epc        (trap_epc),
      .mret_commit     (mret_commit),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .irq_pending     (irq_pending),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      exc_valid = 0; exc_cause = 0; exc_pc = 0; mret_valid = 0; irq_pc = 0;
      irq_ext = 0; irq_timer = 0; irq_soft = 0; csr_mstatus_mie = 0;
      csr_mie = 0; csr_mtvec = 0; csr_mepc = 0; pipe_drained = 1;
   endtask

   // Architectural prediction of which event wins and what the CSR file should see
   function automatic pred_t predict(bit ev, bit mv, logic [4:0] ec, logic [31:0] epc_in,
                                     logic [31:0] ipc, bit gie, logic [31:0] mie,
                                     bit pe, bit pt, bit ps, logic [31:0] mtvec,
                                     logic [31:0] mepc, logic [31:0] old_cause,
                                     logic [31:0] old_epc);
      pred_t p;
      int codes [3] = '{11, 3, 7};
      bit pend  [3];
      pend[0] = pe; pend[1] = ps; pend[2] = pt;
      p.kind = 0; p.cause = old_cause; p.epc = old_epc; p.target = 0;
      if (ev) begin
         p.kind = 1; p.cause = 32'(ec); p.epc = epc_in; p.target = mtvec & ~32'd3;
      end else if (mv) begin
         p.kind = 2; p.target = mepc & ~32'd1;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (p.kind == 0 && gie && mie[codes[k]] && pend[k]) begin
               p.kind  = 1;
               p.cause = 32'h8000_0000 + 32'(codes[k]);
               p.epc   = ipc;
               p.target = mtvec & ~32'd3;
`ifdef VECTORED_MTVEC_EN
               if (mtvec % 4 == 1) p.target = p.target + 32'(4 * codes[k]);
`endif
            end
         end
      end
      return p;
   endfunction

   task automatic test_reset();
      quiet();
      reset_n = 0;
      step(); step();
      checks++;
      if ({flush, stall_fetch, trap_commit, mret_commit, redirect_valid, busy,
           irq_pending, trap_cause, trap_epc, redirect_pc} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got busy=%b flush=%b cause=%h epc=%h pc=%h, need all 0",
                  busy, flush, trap_cause, trap_epc, redirect_pc);
      end
      reset_n = 1;
      step();
      // start an exception sequence and reset it while draining
      csr_mtvec = 32'h400; exc_cause = 5'd4; exc_pc = 32'h80; pipe_drained = 0;
      exc_valid = 1;
      step();
      exc_valid = 0;
      step();
      reset_n = 0;
      step(); step(); step();
      reset_n = 1; pipe_drained = 1;
      step();
      checks++;
      if ({flush, stall_fetch, trap_commit, mret_commit, redirect_valid, busy,
           irq_pending, trap_cause, trap_epc, redirect_pc} !== '0) begin
         failures++;
         $display("FAIL reset_mid_drain: got busy=%b cause=%h epc=%h pc=%h, need all 0",
                  busy, trap_cause, trap_epc, redirect_pc);
      end
      begin
         int seen = 0;
         for (int i = 0; i < 8; i++) begin
            step();
            if (trap_commit || redirect_valid || busy) seen++;
         end
         checks++;
         if (seen !== 0) begin
            failures++;
            $display("FAIL reset_abort: got %0d active cycles after reset, need 0", seen);
         end
      end
   endtask

   task automatic test_exception();
      quiet();
      csr_mtvec = 32'h801; exc_cause = 5'd2; exc_pc = 32'h100;
      exc_valid = 1;
      step();                                   // N+1
      exc_valid = 0;
      checks++;
      if ({flush, stall_fetch, busy} !== 3'b111) begin
         failures++;
         $display("FAIL exc_flush: got flush/stall/busy=%b, need 111", {flush, stall_fetch, busy});
      end
      step();                                   // N+2
      checks++;
      if ({flush, trap_commit} !== 2'b00) begin
         failures++;
         $display("FAIL exc_drain: got flush/commit=%b, need 00", {flush, trap_commit});
      end
      step();                                   // N+3
      checks++;
      if ({trap_commit, mret_commit, trap_cause, trap_epc} !== {2'b10, 32'h2, 32'h100}) begin
         failures++;
         $display("FAIL exc_commit: got tc=%b mc=%b cause=%h epc=%h, need 1 0 2 100",
                  trap_commit, mret_commit, trap_cause, trap_epc);
      end
      step();                                   // N+4
      checks++;
      if ({redirect_valid, stall_fetch, redirect_pc} !== {2'b11, 32'h800}) begin
         failures++;
         $display("FAIL exc_redirect: got rv=%b pc=%h, need 1 800", redirect_valid, redirect_pc);
      end
      step();                                   // N+5
      checks++;
      if ({busy, stall_fetch, redirect_valid} !== 3'b000) begin
         failures++;
         $display("FAIL exc_idle: got busy/stall/rv=%b, need 000", {busy, stall_fetch, redirect_valid});
      end
   endtask

   task automatic test_priority();
      quiet();
      csr_mtvec = 32'h2000; csr_mepc = 32'h300; csr_mie = 32'h80; irq_pc = 32'h444;
      exc_cause = 5'd5; exc_pc = 32'h120;
      irq_timer = 1;
      step(); step();
      exc_valid = 1; mret_valid = 1; csr_mstatus_mie = 1;
      step();                                   // N+1
      exc_valid = 0; mret_valid = 0;
      step(); step();                           // N+3
      checks++;
      if ({trap_commit, mret_commit, trap_cause, trap_epc} !== {2'b10, 32'h5, 32'h120}) begin
         failures++;
         $display("FAIL prio_exc_wins: got tc=%b mc=%b cause=%h epc=%h, need 1 0 5 120",
                  trap_commit, mret_commit, trap_cause, trap_epc);
      end
      step(); step();                           // N+5 idle, timer taken at its end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL prio_gap: got busy=%b, need 0", busy);
      end
      step();                                   // N+6
      checks++;
      if (flush !== 1'b1) begin
         failures++;
         $display("FAIL prio_timer_flush: got flush=%b, need 1", flush);
      end
      step(); step();                           // N+8
      checks++;
      if ({trap_commit, trap_cause, trap_epc} !== {1'b1, 32'h8000_0007, 32'h444}) begin
         failures++;
         $display("FAIL prio_timer_commit: got tc=%b cause=%h epc=%h, need 1 80000007 444",
                  trap_commit, trap_cause, trap_epc);
      end
      csr_mstatus_mie = 0; irq_timer = 0;
      step(); step(); step();
   endtask

   task automatic test_ext_irq();
      quiet();
      csr_mtvec = 32'h600; csr_mie = 32'h800; irq_pc = 32'h9a0;
      irq_ext = 1;
      step(); step();
      checks++;
      if (irq_pending[2] !== 1'b0) begin
         failures++;
         $display("FAIL ext_sync_early: got pending[2]=%b, need 0", irq_pending[2]);
      end
      step();
      checks++;
      if ({irq_pending[2], flush, busy} !== 3'b100) begin
         failures++;
         $display("FAIL ext_sync_pending: got pend/flush/busy=%b, need 100",
                  {irq_pending[2], flush, busy});
      end
      csr_mstatus_mie = 1;
      step();
      csr_mstatus_mie = 0;
      checks++;
      if (flush !== 1'b1) begin
         failures++;
         $display("FAIL ext_flush: got flush=%b, need 1", flush);
      end
      step(); step();
      checks++;
      if ({trap_commit, trap_cause, trap_epc} !== {1'b1, 32'h8000_000B, 32'h9a0}) begin
         failures++;
         $display("FAIL ext_commit: got tc=%b cause=%h epc=%h, need 1 8000000b 9a0",
                  trap_commit, trap_cause, trap_epc);
      end
      irq_ext = 0;
      step(); step(); step();
   endtask

   task automatic test_mret_drain();
      int first = -1;
      int pulses = 0;
      int tpulses = 0;
      logic [31:0] rpc = 0;
      quiet();
      csr_mepc = 32'h205; csr_mtvec = 32'h1000;
      mret_valid = 1;
      step();                                   // N+1
      mret_valid = 0; pipe_drained = 0;
      for (int i = 2; i <= 12; i++) begin
         step();
         if (i == 5) pipe_drained = 1;
         if (mret_commit) begin
            pulses++;
            if (first < 0) first = i;
         end
         if (trap_commit) tpulses++;
         if (redirect_valid) rpc = redirect_pc;
      end
      checks++;
      if (first !== 6 || pulses !== 1 || tpulses !== 0) begin
         failures++;
         $display("FAIL mret_drain: got commit cycle %0d pulses %0d trap %0d, need 6 1 0",
                  first, pulses, tpulses);
      end
      checks++;
      if (rpc !== 32'h204) begin
         failures++;
         $display("FAIL mret_redirect: got %h, need 204", rpc);
      end
   endtask

   task automatic test_vectored();
      logic [31:0] want;
`ifdef VECTORED_MTVEC_EN
      want = 32'h100C;
`else
      want = 32'h1000;
`endif
      quiet();
      csr_mtvec = 32'h1001; csr_mie = 32'h8; irq_soft = 1; irq_pc = 32'h50;
      step(); step();
      csr_mstatus_mie = 1;
      step();
      csr_mstatus_mie = 0;
      step(); step();
      checks++;
      if ({trap_commit, trap_cause} !== {1'b1, 32'h8000_0003}) begin
         failures++;
         $display("FAIL vec_commit: got tc=%b cause=%h, need 1 80000003", trap_commit, trap_cause);
      end
      step();
      checks++;
      if ({redirect_valid, redirect_pc} !== {1'b1, want}) begin
         failures++;
         $display("FAIL vec_redirect: got rv=%b pc=%h, need 1 %h", redirect_valid, redirect_pc, want);
      end
      irq_soft = 0;
      step(); step();
   endtask

   task automatic test_random();
      logic [31:0] old_cause = 0;
      logic [31:0] old_epc = 0;
      quiet();
      reset_n = 0;
      step();
      reset_n = 1;
      for (int it = 0; it < 24; it++) begin
         pred_t p;
         bit pe, pt, ps, ev, mv, gie;
         int len;
         int commit_i = -1;
         int redir_i = -1;
         int npulse = 0;
         logic [1:0]  ckind = 0;
         logic [31:0] got_cause = 0, got_epc = 0, got_pc = 0;
         bit flush_ok;
         quiet();
         pe = 1'($urandom); pt = 1'($urandom); ps = 1'($urandom);
         irq_ext = pe; irq_timer = pt; irq_soft = ps;
         csr_mie   = $urandom;
         csr_mtvec = $urandom;
         csr_mepc  = $urandom;
         irq_pc    = $urandom;
         exc_pc    = $urandom;
         exc_cause = 5'($urandom);
         step(); step(); step(); step();
         ev  = ($urandom_range(0, 2) == 0);
         mv  = ($urandom_range(0, 2) == 0);
         gie = 1'($urandom);
         len = $urandom_range(1, 4);
         p = predict(ev, mv, exc_cause, exc_pc, irq_pc, gie, csr_mie, pe, pt, ps,
                     csr_mtvec, csr_mepc, old_cause, old_epc);
         exc_valid = ev; mret_valid = mv; csr_mstatus_mie = gie; pipe_drained = 0;
         step();                                // N+1
         exc_valid = 0; mret_valid = 0; csr_mstatus_mie = 0;
         flush_ok = (flush === (p.kind != 0));
         for (int i = 1; i <= 14; i++) begin
            if (i > 1) step();
            if (i == len + 1) pipe_drained = 1;
            if (trap_commit || mret_commit) begin
               npulse++;
               if (commit_i < 0) begin
                  commit_i = i; ckind = {mret_commit, trap_commit};
                  got_cause = trap_cause; got_epc = trap_epc;
               end
            end
            if (redirect_valid && redir_i < 0) begin
               redir_i = i; got_pc = redirect_pc;
            end
         end
         pipe_drained = 1;
         checks++;
         if (!flush_ok) begin
            failures++;
            $display("FAIL rand%0d_flush: got flush=%b, need %0d", it, flush, p.kind != 0);
         end
         if (p.kind == 0) begin
            checks++;
            if (npulse !== 0 || redir_i !== -1) begin
               failures++;
               $display("FAIL rand%0d_none: got %0d commits, need 0", it, npulse);
            end
         end else begin
            checks++;
            if (commit_i !== len + 2 || npulse !== 1 || ckind !== p.kind) begin
               failures++;
               $display("FAIL rand%0d_commit: got cycle %0d pulses %0d kind %0d, need %0d 1 %0d",
                        it, commit_i, npulse, ckind, len + 2, p.kind);
            end
            checks++;
            if (got_cause !== p.cause || got_epc !== p.epc) begin
               failures++;
               $display("FAIL rand%0d_csr: got cause=%h epc=%h, need %h %h",
                        it, got_cause, got_epc, p.cause, p.epc);
            end
            checks++;
            if (redir_i !== len + 3 || got_pc !== p.target) begin
               failures++;
               $display("FAIL rand%0d_redirect: got cycle %0d pc=%h, need %0d %h",
                        it, redir_i, got_pc, len + 3, p.target);
            end
         end
         checks++;
         if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rand%0d_end_idle: got busy=%b, need 0", it, busy);
         end
         old_cause = p.cause;
         old_epc   = p.epc;
      end
   endtask

   initial begin
      quiet();
      reset_n = 0;
      test_reset();
      test_exception();
      test_priority();
      test_ext_irq();
      test_mret_drain();
      test_vectored();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
